button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumes the clean, synchronous, debounced button level produced by the input-conditioning stage.
- Converts it into single-cycle event pulses: press, release, click, double-click, long-press and auto-repeat.
- Sits between the debouncer and the control FSMs, so that no downstream block does its own edge detection or hold timing.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz; CYC_PER_MS = CLK_FREQ/1000.
- LONG_PRESS_MS, 1000, hold time before long_pulse; must be >= 1.
- REPEAT_MS, 200, auto-repeat period after a long press; must be >= 1.
- DCLICK_MS, 300, window after a short-press release in which a second press counts as a double click; must be >= 1.
- ACTIVE_LOW, 1, 1: btn_in = 0 means pressed; 0: btn_in = 1 means pressed.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- btn_in  input  1  debounced button level, already synchronous to clk
- pressed  output  1  registered "button is down" level, polarity-normalised (1 = down)
- press_pulse  output  1  one-cycle pulse on each press
- release_pulse  output  1  one-cycle pulse on each release
- click_pulse  output  1  one-cycle pulse: short press confirmed as a single click
- dclick_pulse  output  1  one-cycle pulse: second press inside the double-click window
- long_pulse  output  1  one-cycle pulse: hold reached LONG_PRESS_MS
- repeat_pulse  output  1  one-cycle pulse every REPEAT_MS while held after long_pulse

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs 0, state IDLE, timers 0, previous-level register = released level (1 if ACTIVE_LOW, else 0).
- Level normalisation: down = btn_in XOR ACTIVE_LOW.
- Edge detection: compare down against the registered previous level. All outputs are registered, so every pulse appears one cycle after the btn_in change that causes it.
- Timer: ms prescaler counting 0..CYC_PER_MS-1, followed by a ms counter. Both clear on every state transition, so durations are measured exactly from the transition cycle. Widths are $clog2 of the maximum value each must hold.
- FSM states:
  - IDLE: on press -> press_pulse, go to PRESS1.
  - PRESS1 (first press, short so far):
    - release -> release_pulse, go to WAIT2.
    - ms count reaches LONG_PRESS_MS -> long_pulse, go to HELD.
  - WAIT2 (released, double-click window open):
    - press -> press_pulse and dclick_pulse in the same cycle, go to PRESS2.
    - ms count reaches DCLICK_MS -> click_pulse, go to IDLE.
  - PRESS2 (second press of a double click):
    - release -> release_pulse, go to IDLE; no window is armed.
    - LONG_PRESS_MS reached -> long_pulse, go to HELD.
  - HELD:
    - every REPEAT_MS -> repeat_pulse; the first repeat comes REPEAT_MS after long_pulse.
    - release -> release_pulse, go to IDLE; no click_pulse.
- Timing from press_pulse:
  - long_pulse fires exactly LONG_PRESS_MS*CYC_PER_MS cycles after press_pulse.
  - repeat_pulse k fires (LONG_PRESS_MS + k*REPEAT_MS)*CYC_PER_MS cycles after press_pulse.
- Simultaneous events: an edge always wins over timer expiry in the same cycle.
  - Release on the long-threshold cycle -> release_pulse only, go to WAIT2.
  - Press on the DCLICK-expiry cycle -> double click; no click_pulse.
  - Release on a repeat cycle -> release_pulse only.
- At most one of click/dclick/long/repeat is asserted per cycle. press_pulse may coincide only with dclick_pulse.
- pressed follows down with one cycle of latency, independent of the FSM.
- Reset mid-operation: immediate return to reset values. If the button is held through reset deassertion, the first clock edge after release of reset produces press_pulse one cycle later (normal edge path).
- A third press after a double click starts a fresh sequence from IDLE.

Test Plan:
Bench parameters: CLK_FREQ=10_000 (CYC_PER_MS=10), LONG_PRESS_MS=5, REPEAT_MS=2, DCLICK_MS=3, ACTIVE_LOW=1.
1. Single click: drive btn_in 0 for 20 cycles, then 1 -> press_pulse at cycle 1, release_pulse at cycle 21, click_pulse exactly 30 cycles after release_pulse, no other pulses.
2. Double click: press 10 cycles, release 10 cycles, press 10 cycles, release -> second press gives press_pulse and dclick_pulse in the same cycle; a single release_pulse at the end; no click_pulse.
3. Long press and repeat: hold 120 cycles -> long_pulse 50 cycles after press_pulse; repeat_pulse at +70, +90, +110; release gives release_pulse only, no click.
4. Boundary cases:
   - release on exactly cycle 50 after press_pulse -> release_pulse, no long_pulse, then click_pulse 30 cycles later;
   - second press on exactly the expiry cycle -> dclick_pulse, no click_pulse.
5. Reset mid-hold: assert rst_n=0 at cycle 60 of a hold -> all outputs 0 immediately; release rst_n with btn_in still 0 -> press_pulse next cycle, long_pulse 50 cycles later.
6. Polarity: ACTIVE_LOW=0, repeat scenario 1 with inverted btn_in -> identical pulse timing; pressed = btn_in delayed one cycle.

Source files
------------

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/click/double-click/
// long-press/auto-repeat pulses. Every output is registered (one cycle after the input edge).
module button_event_decoder #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200,
  parameter int DCLICK_MS     = 300,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic dclick_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int CYC_PER_MS = CLK_FREQ / 1000;
  localparam int PW         = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam int MS_MAX_A   = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int MS_MAX     = (MS_MAX_A > DCLICK_MS) ? MS_MAX_A : DCLICK_MS;
  localparam int MW         = $clog2(MS_MAX + 1);

  localparam logic          AL          = (ACTIVE_LOW != 0);
  localparam logic [PW-1:0] PRE_LAST    = PW'(CYC_PER_MS - 1);
  localparam logic [MW-1:0] LONG_LAST   = MW'(LONG_PRESS_MS - 1);
  localparam logic [MW-1:0] REPEAT_LAST = MW'(REPEAT_MS - 1);
  localparam logic [MW-1:0] DCLICK_LAST = MW'(DCLICK_MS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_prev_btn;
  logic          r_pressed;
  logic [PW-1:0] r_pre;
  logic [MW-1:0] r_ms;
  logic          r_press, r_release, r_click, r_dclick, r_long, r_repeat;

  logic w_down, w_prev_down, w_rise, w_fall;
  logic w_ms_tick, w_long_hit, w_repeat_hit, w_dclick_hit;
  logic w_tmr_clr;
  logic w_press_n, w_release_n, w_click_n, w_dclick_n, w_long_n, w_repeat_n;

  assign w_down      = btn_in ^ AL;
  assign w_prev_down = r_prev_btn ^ AL;
  assign w_rise      = w_down & ~w_prev_down;
  assign w_fall      = ~w_down & w_prev_down;

  // A hit means the duration elapses on this edge, so the pulse lands exactly
  // N*CYC_PER_MS cycles after the edge that cleared the timer.
  assign w_ms_tick    = (r_pre == PRE_LAST);
  assign w_long_hit   = w_ms_tick && (r_ms == LONG_LAST);
  assign w_repeat_hit = w_ms_tick && (r_ms == REPEAT_LAST);
  assign w_dclick_hit = w_ms_tick && (r_ms == DCLICK_LAST);

  // Edges are tested before timer hits in every state so an edge always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b0;
    w_press_n   = 1'b0;
    w_release_n = 1'b0;
    w_click_n   = 1'b0;
    w_dclick_n  = 1'b0;
    w_long_n    = 1'b0;
    w_repeat_n  = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmr_clr = 1'b1;
        if (w_rise) begin
          w_press_n   = 1'b1;
          w_state_nxt = PRESS1;
        end
      end
      PRESS1: begin
        if (w_fall) begin
          w_release_n = 1'b1;
          w_state_nxt = WAIT2;
          w_tmr_clr   = 1'b1;
        end else if (w_long_hit) begin
          w_long_n    = 1'b1;
          w_state_nxt = HELD;
          w_tmr_clr   = 1'b1;
        end
      end
      WAIT2: begin
        if (w_rise) begin
          w_press_n   = 1'b1;
          w_dclick_n  = 1'b1;
          w_state_nxt = PRESS2;
          w_tmr_clr   = 1'b1;
        end else if (w_dclick_hit) begin
          w_click_n   = 1'b1;
          w_state_nxt = IDLE;
          w_tmr_clr   = 1'b1;
        end
      end
      PRESS2: begin
        if (w_fall) begin
          w_release_n = 1'b1;
          w_state_nxt = IDLE;
          w_tmr_clr   = 1'b1;
        end else if (w_long_hit) begin
          w_long_n    = 1'b1;
          w_state_nxt = HELD;
          w_tmr_clr   = 1'b1;
        end
      end
      HELD: begin
        if (w_fall) begin
          w_release_n = 1'b1;
          w_state_nxt = IDLE;
          w_tmr_clr   = 1'b1;
        end else if (w_repeat_hit) begin
          w_repeat_n  = 1'b1;
          w_tmr_clr   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tmr_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_prev_btn <= AL;
      r_pressed  <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_click    <= 1'b0;
      r_dclick   <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_btn <= btn_in;
      r_pressed  <= w_down;
      r_press    <= w_press_n;
      r_release  <= w_release_n;
      r_click    <= w_click_n;
      r_dclick   <= w_dclick_n;
      r_long     <= w_long_n;
      r_repeat   <= w_repeat_n;
    end
  end

  // ms prescaler feeding the ms counter; both restart on every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (w_tmr_clr) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (w_ms_tick) begin
      r_pre <= '0;
      r_ms  <= r_ms + MW'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign click_pulse   = r_click;
  assign dclick_pulse  = r_dclick;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboarded bench: each scenario queues the pulses it expects (cycle + pulse vector)
// and compares them against pulses captured from the decoder on falling edges.
module tb_button_event_decoder;

  localparam int CLK_FREQ = 10_000;
  localparam int LP       = 5;
  localparam int RP       = 2;
  localparam int DC       = 3;

  // pulse vector bit order: press, release, click, dclick, long, repeat
  localparam logic [5:0] E_PRESS  = 6'b100000;
  localparam logic [5:0] E_REL    = 6'b010000;
  localparam logic [5:0] E_CLICK  = 6'b001000;
  localparam logic [5:0] E_DCLICK = 6'b000100;
  localparam logic [5:0] E_LONG   = 6'b000010;
  localparam logic [5:0] E_REP    = 6'b000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b1;
  logic btn_ah = 1'b0;

  logic pressed, press_pulse, release_pulse, click_pulse, dclick_pulse, long_pulse, repeat_pulse;
  logic pressed_ah, press_ah, release_ah, click_ah, dclick_ah, long_ah, repeat_ah;

  button_event_decoder #(
    .CLK_FREQ(CLK_FREQ), .LONG_PRESS_MS(LP), .REPEAT_MS(RP), .DCLICK_MS(DC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .click_pulse(click_pulse), .dclick_pulse(dclick_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  button_event_decoder #(
    .CLK_FREQ(CLK_FREQ), .LONG_PRESS_MS(LP), .REPEAT_MS(RP), .DCLICK_MS(DC), .ACTIVE_LOW(0)
  ) dut_ah (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_ah),
    .pressed(pressed_ah), .press_pulse(press_ah), .release_pulse(release_ah),
    .click_pulse(click_ah), .dclick_pulse(dclick_ah), .long_pulse(long_ah),
    .repeat_pulse(repeat_ah)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } ev_t;

  ev_t exp_q[$], obs_q[$], exp_ah_q[$], obs_ah_q[$];
  int checks = 0;
  int failures = 0;

  logic [5:0] vec, vec_ah;
  assign vec    = {press_pulse, release_pulse, click_pulse, dclick_pulse, long_pulse, repeat_pulse};
  assign vec_ah = {press_ah, release_ah, click_ah, dclick_ah, long_ah, repeat_ah};

  always @(negedge clk) begin
    ev_t ev;
    if (rst_n === 1'b1) begin
      if (vec !== 6'b0) begin
        ev.cyc = cyc; ev.v = vec; obs_q.push_back(ev);
      end
      if (vec_ah !== 6'b0) begin
        ev.cyc = cyc; ev.v = vec_ah; obs_ah_q.push_back(ev);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [5:0] v);
    ev_t ev;
    ev.cyc = c; ev.v = v;
    exp_q.push_back(ev);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vec, pressed, vec_ah, pressed_ah} !== 14'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {vec, pressed, vec_ah, pressed_ah});
    end
    rst_n = 1'b1;
    step(3);
    checks++;
    if (obs_q.size() + obs_ah_q.size() != 0 || pressed !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got events=%0d pressed=%b want events=0 pressed=0",
               obs_q.size() + obs_ah_q.size(), pressed);
    end
    obs_q.delete(); obs_ah_q.delete();
  endtask

  task automatic test_single_click();
    ev_t e, o;
    int t0;
    t0 = cyc;
    btn = 1'b0;
    expect_ev(t0 + 1, E_PRESS);
    expect_ev(t0 + 21, E_REL);
    expect_ev(t0 + 51, E_CLICK);
    @(negedge clk);
    checks++;
    if (pressed !== 1'b0) begin
      failures++; $display("FAIL click_pressed_lag got=%b want=0", pressed);
    end
    @(negedge clk);
    checks++;
    if (pressed !== 1'b1) begin
      failures++; $display("FAIL click_pressed_set got=%b want=1", pressed);
    end
    step(19);
    btn = 1'b1;
    step(45);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL click_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.v !== e.v) begin
        failures++;
        $display("FAIL click_event got cyc=%0d v=%b want cyc=%0d v=%b", o.cyc - t0, o.v, e.cyc - t0, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_double_click();
    ev_t e, o;
    int t0;
    t0 = cyc;
    btn = 1'b0;
    expect_ev(t0 + 1, E_PRESS);
    expect_ev(t0 + 11, E_REL);
    expect_ev(t0 + 21, E_PRESS | E_DCLICK);
    expect_ev(t0 + 31, E_REL);
    step(10); btn = 1'b1;
    step(10); btn = 1'b0;
    step(10); btn = 1'b1;
    step(50);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL dclick_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.v !== e.v) begin
        failures++;
        $display("FAIL dclick_event got cyc=%0d v=%b want cyc=%0d v=%b", o.cyc - t0, o.v, e.cyc - t0, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_long_repeat();
    ev_t e, o;
    int t0;
    t0 = cyc;
    btn = 1'b0;
    expect_ev(t0 + 1, E_PRESS);
    expect_ev(t0 + 51, E_LONG);
    expect_ev(t0 + 71, E_REP);
    expect_ev(t0 + 91, E_REP);
    expect_ev(t0 + 111, E_REP);
    expect_ev(t0 + 121, E_REL);
    step(120); btn = 1'b1;
    step(50);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL long_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.v !== e.v) begin
        failures++;
        $display("FAIL long_event got cyc=%0d v=%b want cyc=%0d v=%b", o.cyc - t0, o.v, e.cyc - t0, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_boundaries();
    ev_t e, o;
    int t0;
    // release on the long-threshold cycle, then the click window runs out
    t0 = cyc;
    btn = 1'b0;
    expect_ev(t0 + 1, E_PRESS);
    expect_ev(t0 + 51, E_REL);
    expect_ev(t0 + 81, E_CLICK);
    step(50); btn = 1'b1;
    step(40);
    // second press lands on the click-window expiry cycle
    t0 = cyc;
    btn = 1'b0;
    expect_ev(t0 + 1, E_PRESS);
    expect_ev(t0 + 11, E_REL);
    expect_ev(t0 + 41, E_PRESS | E_DCLICK);
    expect_ev(t0 + 51, E_REL);
    step(10); btn = 1'b1;
    step(30); btn = 1'b0;
    step(10); btn = 1'b1;
    step(40);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bound_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.v !== e.v) begin
        failures++;
        $display("FAIL bound_event got cyc=%0d v=%b want cyc=%0d v=%b", o.cyc, o.v, e.cyc, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_hold();
    ev_t e, o;
    int t0, t1;
    t0 = cyc;
    btn = 1'b0;
    expect_ev(t0 + 1, E_PRESS);
    expect_ev(t0 + 51, E_LONG);
    step(60);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec, pressed} !== 7'b0) begin
      failures++; $display("FAIL rst_mid_outputs got=%b want=0", {vec, pressed});
    end
    step(3);
    t1 = cyc;
    rst_n = 1'b1;
    expect_ev(t1 + 1, E_PRESS);
    expect_ev(t1 + 51, E_LONG);
    expect_ev(t1 + 56, E_REL);
    step(55); btn = 1'b1;
    step(50);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rst_mid_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.v !== e.v) begin
        failures++;
        $display("FAIL rst_mid_event got cyc=%0d v=%b want cyc=%0d v=%b", o.cyc, o.v, e.cyc, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_polarity();
    ev_t e, o, ev;
    int t0;
    t0 = cyc;
    btn_ah = 1'b1;
    ev.cyc = t0 + 1;  ev.v = E_PRESS; exp_ah_q.push_back(ev);
    ev.cyc = t0 + 21; ev.v = E_REL;   exp_ah_q.push_back(ev);
    ev.cyc = t0 + 51; ev.v = E_CLICK; exp_ah_q.push_back(ev);
    @(negedge clk);
    checks++;
    if (pressed_ah !== 1'b0) begin
      failures++; $display("FAIL pol_pressed_lag got=%b want=0", pressed_ah);
    end
    @(negedge clk);
    checks++;
    if (pressed_ah !== 1'b1) begin
      failures++; $display("FAIL pol_pressed_set got=%b want=1", pressed_ah);
    end
    step(19);
    btn_ah = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pressed_ah !== 1'b0) begin
      failures++; $display("FAIL pol_pressed_clr got=%b want=0", pressed_ah);
    end
    step(40);
    checks++;
    if (obs_ah_q.size() != exp_ah_q.size() || obs_q.size() != 0) begin
      failures++;
      $display("FAIL pol_count got=%0d/%0d want=%0d/0", obs_ah_q.size(), obs_q.size(), exp_ah_q.size());
    end
    while (exp_ah_q.size() > 0 && obs_ah_q.size() > 0) begin
      e = exp_ah_q.pop_front(); o = obs_ah_q.pop_front();
      checks++;
      if (o.cyc != e.cyc || o.v !== e.v) begin
        failures++;
        $display("FAIL pol_event got cyc=%0d v=%b want cyc=%0d v=%b", o.cyc - t0, o.v, e.cyc - t0, e.v);
      end
    end
    exp_ah_q.delete(); obs_ah_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_click();
    test_double_click();
    test_long_repeat();
    test_boundaries();
    test_reset_mid_hold();
    test_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
